// File: rtl/sm_cpz_vic_pkg.sv
// Shared constants for the vectored-interrupt CP0: register map, field
// positions, exception codes and handler offsets.
package sm_cpz_vic_pkg;

  // {regNum, regSel} keys for the MTC0/MFC0 decode
  localparam logic [7:0] R_COUNT   = {5'd9,  3'd0};
  localparam logic [7:0] R_COMPARE = {5'd11, 3'd0};
  localparam logic [7:0] R_STATUS  = {5'd12, 3'd0};
  localparam logic [7:0] R_INTCTL  = {5'd12, 3'd1};
  localparam logic [7:0] R_CAUSE   = {5'd13, 3'd0};
  localparam logic [7:0] R_EPC     = {5'd14, 3'd0};
  localparam logic [7:0] R_EBASE   = {5'd15, 3'd1};

  localparam logic [4:0] EXC_INT = 5'h00;
  localparam logic [4:0] EXC_RI  = 5'h0A;
  localparam logic [4:0] EXC_OV  = 5'h0C;

  localparam int ST_IE     = 0;
  localparam int ST_EXL    = 1;
  localparam int ST_IM_LO  = 8;
  localparam int IC_VS_LO  = 5;
  localparam int CA_IP_LO  = 8;
  localparam int CA_IV     = 23;
  localparam int CA_DC     = 27;
  localparam int CA_TI     = 30;

  localparam logic [31:0] OFF_GEN = 32'h0000_0180;
  localparam logic [31:0] OFF_VEC = 32'h0000_0200;

  // Highest set bit index of an 8-bit pending vector (0 when empty)
  function automatic logic [2:0] hi_idx(input logic [7:0] v);
    hi_idx = 3'd0;
    for (int i = 0; i < 8; i++)
      if (v[i]) hi_idx = 3'(i);
  endfunction

endpackage

// File: rtl/sm_cpz_irq_in.sv
// One hardware interrupt line: 2-flop synchroniser, optionally followed by a
// rising-edge latch that holds until software clears it.
module sm_cpz_irq_in #(
  parameter bit EDGE = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic irq_i,
  input  logic clr_i,
  output logic pend_o
);

  logic meta_q, sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= irq_i;
      sync_q <= meta_q;
    end
  end

  if (EDGE) begin : g_edge
    // Edge is detected on synchronised samples only; a new edge beats a clear
    logic prev_q, lat_q, lat_d;
    assign lat_d = (sync_q & ~prev_q) | (lat_q & ~clr_i);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        prev_q <= 1'b0;
        lat_q  <= 1'b0;
      end else begin
        prev_q <= sync_q;
        lat_q  <= lat_d;
      end
    end

    assign pend_o = lat_q;
  end else begin : g_level
    logic unused_clr;
    assign unused_clr = clr_i;
    assign pend_o     = sync_q;
  end

endmodule

// File: rtl/sm_cpz_vic.sv
// Coprocessor 0 with hardware interrupt lines, prescaled Count/Compare timer
// and vectored interrupt dispatch for the schoolMIPS core.
module sm_cpz_vic #(
  parameter int          HWINT_NUM      = 6,
  parameter logic [5:0]  EDGE_MASK      = 6'b000000,
  parameter int          COUNT_DIV_LOG2 = 0,
  parameter logic [31:0] EBASE_RESET    = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          cp0_PC,
  output logic [31:0]          cp0_EPC,
  output logic [31:0]          cp0_ExcHandler,
  output logic                 cp0_ExcAsync,
  output logic                 cp0_ExcSync,
  input  logic                 cp0_ExcEret,
  input  logic [4:0]           cp0_regNum,
  input  logic [2:0]           cp0_regSel,
  output logic [31:0]          cp0_regRD,
  input  logic [31:0]          cp0_regWD,
  input  logic                 cp0_regWE,
  input  logic [HWINT_NUM-1:0] cp0_ExcIP,
  input  logic                 cp0_ExcRI,
  input  logic                 cp0_ExcOv,
  output logic                 cp0_TI
);
  import sm_cpz_vic_pkg::*;

  logic [31:0] count_q, count_d, compare_q, compare_d, epc_q, epc_d;
  logic [7:0]  im_q, im_d;
  logic        exl_q, exl_d, ie_q, ie_d;
  logic [4:0]  vs_q, vs_d;
  logic        ti_q, ti_d, dc_q, dc_d, iv_q, iv_d;
  logic [1:0]  swip_q, swip_d;
  logic [4:0]  exc_q, exc_d;
  logic [19:0] ebase_q, ebase_d;

  logic [7:0] key;
  logic       we_count, we_compare, we_status, we_intctl, we_cause, we_epc, we_ebase;

  assign key        = {cp0_regNum, cp0_regSel};
  assign we_count   = cp0_regWE && (key == R_COUNT);
  assign we_compare = cp0_regWE && (key == R_COMPARE);
  assign we_status  = cp0_regWE && (key == R_STATUS);
  assign we_intctl  = cp0_regWE && (key == R_INTCTL);
  assign we_cause   = cp0_regWE && (key == R_CAUSE);
  assign we_epc     = cp0_regWE && (key == R_EPC);
  assign we_ebase   = cp0_regWE && (key == R_EBASE);

  // Hardware lines; an MTC0 Cause writing 0 to a line's IP bit clears its latch
  logic [HWINT_NUM-1:0] hw_pend, hw_clr;

  for (genvar k = 0; k < HWINT_NUM; k++) begin : g_irq
    assign hw_clr[k] = we_cause & ~cp0_regWD[CA_IP_LO+2+k];
    sm_cpz_irq_in #(.EDGE(EDGE_MASK[k])) u_irq (
      .clk    (clk),
      .rst_n  (rst_n),
      .irq_i  (cp0_ExcIP[k]),
      .clr_i  (hw_clr[k]),
      .pend_o (hw_pend[k])
    );
  end

  logic [7:0] ip;
  always_comb begin
    ip      = '0;
    ip[1:0] = swip_q;
    for (int k = 0; k < HWINT_NUM; k++) ip[2+k] = hw_pend[k];
    ip[7]   = ip[7] | ti_q;
  end

  logic async_req, sync_req, accept;
  assign async_req    = ie_q & ~exl_q & (|(ip & im_q));
  assign sync_req     = (cp0_ExcRI | cp0_ExcOv) & ~exl_q;
  assign cp0_ExcSync  = sync_req;
  assign cp0_ExcAsync = async_req & ~sync_req;
  assign accept       = cp0_ExcAsync | cp0_ExcSync;

  logic [31:0] ebase_full, vec_off;
  logic [2:0]  vec;
  assign ebase_full = {ebase_q, 12'h000};
  assign vec        = hi_idx(ip & im_q);
  assign vec_off    = 32'(vec) * (32'(vs_q) << 5);

  always_comb begin
    if (sync_req || !iv_q || (vs_q == 5'd0))
      cp0_ExcHandler = ebase_full + OFF_GEN;
    else
      cp0_ExcHandler = ebase_full + OFF_VEC + vec_off;
  end

  // Count prescaler; a Count load restarts the divide period
  logic tick;
  if (COUNT_DIV_LOG2 == 0) begin : g_nodiv
    assign tick = 1'b1;
  end else begin : g_div
    logic [COUNT_DIV_LOG2-1:0] presc_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        presc_q <= '0;
      else if (we_count) presc_q <= '0;
      else               presc_q <= presc_q + COUNT_DIV_LOG2'(1);
    end
    assign tick = &presc_q;
  end

  always_comb begin
    count_d   = count_q;
    compare_d = compare_q;
    epc_d     = epc_q;
    im_d      = im_q;
    exl_d     = exl_q;
    ie_d      = ie_q;
    vs_d      = vs_q;
    ti_d      = ti_q;
    dc_d      = dc_q;
    iv_d      = iv_q;
    swip_d    = swip_q;
    exc_d     = exc_q;
    ebase_d   = ebase_q;

    if (we_count)                count_d = cp0_regWD;
    else if (tick && !dc_q)      count_d = count_q + 32'd1;

    if (we_compare)              compare_d = cp0_regWD;

    if (we_compare)                           ti_d = 1'b0;
    else if ((count_q == compare_q) && !dc_q) ti_d = 1'b1;

    if (we_status) begin
      im_d  = cp0_regWD[ST_IM_LO +: 8];
      exl_d = cp0_regWD[ST_EXL];
      ie_d  = cp0_regWD[ST_IE];
    end else if (cp0_ExcEret) begin
      exl_d = 1'b0;
    end else if (accept) begin
      exl_d = 1'b1;
    end

    if (we_intctl) vs_d = cp0_regWD[IC_VS_LO +: 5];

    if (we_cause) begin
      dc_d   = cp0_regWD[CA_DC];
      iv_d   = cp0_regWD[CA_IV];
      swip_d = cp0_regWD[CA_IP_LO +: 2];
    end

    if (accept)
      exc_d = !sync_req ? EXC_INT : (cp0_ExcRI ? EXC_RI : EXC_OV);

    if (we_epc)      epc_d = cp0_regWD;
    else if (accept) epc_d = cp0_PC;

    if (we_ebase) ebase_d = cp0_regWD[31:12];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      compare_q <= '0;
      epc_q     <= '0;
      im_q      <= '0;
      exl_q     <= 1'b0;
      ie_q      <= 1'b0;
      vs_q      <= '0;
      ti_q      <= 1'b0;
      dc_q      <= 1'b0;
      iv_q      <= 1'b0;
      swip_q    <= '0;
      exc_q     <= '0;
      ebase_q   <= EBASE_RESET[31:12];
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      epc_q     <= epc_d;
      im_q      <= im_d;
      exl_q     <= exl_d;
      ie_q      <= ie_d;
      vs_q      <= vs_d;
      ti_q      <= ti_d;
      dc_q      <= dc_d;
      iv_q      <= iv_d;
      swip_q    <= swip_d;
      exc_q     <= exc_d;
      ebase_q   <= ebase_d;
    end
  end

  always_comb begin
    cp0_regRD = '0;
    case (key)
      R_COUNT:   cp0_regRD = count_q;
      R_COMPARE: cp0_regRD = compare_q;
      R_STATUS:  cp0_regRD = {16'h0, im_q, 6'h0, exl_q, ie_q};
      R_INTCTL:  cp0_regRD = {22'h0, vs_q, 5'h0};
      R_CAUSE:   cp0_regRD = {1'b0, ti_q, 2'b0, dc_q, 3'b0, iv_q, 7'b0, ip, 1'b0, exc_q, 2'b0};
      R_EPC:     cp0_regRD = epc_q;
      R_EBASE:   cp0_regRD = ebase_full;
      default:   cp0_regRD = '0;
    endcase
  end

  assign cp0_EPC = epc_q;
  assign cp0_TI  = ti_q;

endmodule
